nexi_uart_tx_arbiter: RTL
=========================

// Module: nexi_uart_tx_arbiter
// PURPOSE
//  Shares the UART's single transmit holding register between NUM_REQ byte
//  producers (CPU console, debug monitor, trace, ...). Acts as the sole
//  Wishbone master of the UART slave: configures IER once after reset, then
//  round-robin grants one byte at a time, writes THR, waits for the TX IRQ
//  and clears it by reading ISR. Sits between the producers and the UART.
// PARAMETERS
//  NUM_REQ  4      number of byte requesters (2..8)
//  TIMEOUT  65535  max cycles to wait for irq_i after a THR write (16-bit count)
// PORTS
//  clk_i        in   1          system clock
//  rst_i        in   1          synchronous reset, active-high
//  req_valid_i  in   NUM_REQ    requester r has a byte ready
//  req_data_i   in   8*NUM_REQ  byte of requester r at [8r+7:8r]
//  req_ready_o  out  NUM_REQ    one-cycle pulse: byte of requester r accepted
//  busy_o       out  1          high in every state except IDLE
//  timeout_o    out  1          one-cycle pulse: TX IRQ not seen within TIMEOUT
//  wb_cyc_o     out  1          Wishbone cycle
//  wb_stb_o     out  1          Wishbone strobe (always equal to wb_cyc_o)
//  wb_we_o      out  1          Wishbone write enable
//  wb_addr_o    out  3          fixed 3'b000 (UART decodes on sel)
//  wb_sel_o     out  4          register select: THR 4'b0100, IER 4'b0010, ISR 4'b0001
//  wb_data_o    out  32         write data
//  wb_ack_i     in   1          Wishbone acknowledge from UART
//  wb_data_i    in   32         read data from UART
//  irq_i        in   1          UART interrupt
// BEHAVIOUR
//  Reset: all outputs 0; state INIT_IER; rr pointer 0; timeout counter 0.
//    Applies on any cycle, including mid-bus-cycle. The bus cycle is abandoned
//    and any latched byte is dropped.
//  States and transitions:
//   INIT_IER: cyc=stb=we=1, sel=0010, data={16'h0,8'h01,8'h00} (TX IRQ enable).
//     On wb_ack_i go to RELEASE, with ret=IDLE.
//   RELEASE: cyc=stb=we=0. Stay until wb_ack_i==0, then go to ret.
//     The UART drops ack only after cyc and stb are both low, so every access
//     passes through RELEASE.
//   IDLE: if |req_valid_i:
//     - grant g = first valid index at or after ptr, wrapping modulo NUM_REQ;
//     - same cycle: req_ready_o[g]=1, latch byte, set ptr=(g+1)%NUM_REQ;
//     - go to WR_THR.
//     Otherwise stay in IDLE.
//   WR_THR: cyc=stb=we=1, sel=0100, data={8'h00,byte,16'h0000}.
//     On wb_ack_i go to RELEASE, with ret=WAIT_TX.
//   WAIT_TX: counter clears on entry and increments each cycle.
//     - irq_i==1: go to RD_ISR.
//     - Otherwise, counter==TIMEOUT-1: timeout_o=1 for one cycle, go to RD_ISR.
//     - irq_i has priority over timeout in the same cycle.
//   RD_ISR: cyc=stb=1, we=0, sel=0001. On wb_ack_i go to RELEASE, with ret=IDLE.
//     The UART's read-clear of ISR deasserts irq_i; wb_data_i is ignored.
//  Latencies:
//    - Grant to first THR strobe: 1 cycle.
//    - Minimum request spacing: 4 cycles plus the UART's ack and TX time.
//  Handshake:
//    - Requesters hold valid and data until they see ready.
//    - Valid dropped before grant is never taken; there is no stickiness.
//    - At most one req_ready_o bit is high per cycle; it is never high outside IDLE.
//    - Requests arriving while busy_o is high wait; no byte is lost or duplicated.
//  Round robin: all requesters valid -> grant order 0,1,2,3,0,...
//    A lone requester is granted back to back.
//  Strobes: wb_stb_o equals wb_cyc_o; sel and data are stable for the whole
//    strobe.
// TESTING
//  1. Reset release, UART model acks after 1 cycle -> IER write of 0x00000100
//     with sel 0010, then busy_o=0.
//  2. req 2 valid with data 0x41 -> req_ready_o=4'b0100 for one cycle;
//     THR write data 0x00410000, sel 0100; after irq_i, ISR read sel 0001;
//     returns to IDLE.
//  3. All 4 requesters valid continuously -> bytes emitted in order 0,1,2,3,0;
//     one ready pulse each.
//  4. irq_i never asserted, TIMEOUT=16 -> timeout_o pulse 16 cycles after
//     entering WAIT_TX, ISR read follows, next request served.
//  5. rst_i asserted mid-THR write while stb is high -> next cycle all outputs 0;
//     after release IER is re-initialised and the latched byte is not sent.
//  6. ack_i held high 3 cycles after cyc drops -> no new strobe until ack_i=0.

Source files
------------

// File: rtl/nexi_uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one UART transmit
// holding register, acting as the single Wishbone master of the UART.
module nexi_uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [2:0]             wb_addr_o,
  output logic [3:0]             wb_sel_o,
  output logic [31:0]            wb_data_o,
  input  logic                   wb_ack_i,
  input  logic [31:0]            wb_data_i,
  input  logic                   irq_i
);

  localparam int          PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  SEL_THR = 4'b0100;
  localparam logic [3:0]  SEL_IER = 4'b0010;
  localparam logic [3:0]  SEL_ISR = 4'b0001;

  typedef enum logic [2:0] {
    S_INIT_IER,
    S_RELEASE,
    S_IDLE,
    S_WR_THR,
    S_WAIT_TX,
    S_RD_ISR
  } state_t;

  state_t             r_state, w_state_nxt;
  state_t             r_ret, w_ret_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [7:0]         r_byte;
  logic [15:0]        r_cnt;
  logic               r_cyc, r_we, r_busy, r_timeout;
  logic [3:0]         r_sel;
  logic [31:0]        r_data;

  logic               w_found, w_grant, w_timeout;
  logic [PTR_W-1:0]   w_idx, w_gnt_idx;
  logic [7:0]         w_gnt_byte;
  logic               w_cyc_nxt, w_we_nxt;
  logic [3:0]         w_sel_nxt;
  logic [31:0]        w_data_nxt;
  logic               w_unused_rdata;

  // ISR read data is irrelevant: the read itself clears the interrupt.
  assign w_unused_rdata = ^wb_data_i;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    w_found    = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_byte = '0;
    w_idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && w_idx == PTR_W'(j) && req_valid_i[j]) begin
          w_found    = 1'b1;
          w_gnt_idx  = PTR_W'(j);
          w_gnt_byte = req_data_i[8*j +: 8];
        end
      end
    end
  end

  assign w_ptr_nxt = PTR_W'((int'(w_gnt_idx) + 1) % NUM_REQ);

  // Ack is qualified with r_cyc so a stale ack after reset is not taken.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_INIT_IER: if (wb_ack_i && r_cyc) begin
        w_state_nxt = S_RELEASE;
        w_ret_nxt   = S_IDLE;
      end
      S_RELEASE:  if (!wb_ack_i) w_state_nxt = r_ret;
      S_IDLE:     if (w_found) begin
        w_grant     = 1'b1;
        w_state_nxt = S_WR_THR;
      end
      S_WR_THR:   if (wb_ack_i && r_cyc) begin
        w_state_nxt = S_RELEASE;
        w_ret_nxt   = S_WAIT_TX;
      end
      S_WAIT_TX:  if (irq_i) begin
        w_state_nxt = S_RD_ISR;
      end else if (r_cnt == TO_LAST) begin
        w_timeout   = 1'b1;
        w_state_nxt = S_RD_ISR;
      end
      S_RD_ISR:   if (wb_ack_i && r_cyc) begin
        w_state_nxt = S_RELEASE;
        w_ret_nxt   = S_IDLE;
      end
      default:    w_state_nxt = S_INIT_IER;
    endcase
  end

  // Bus outputs are registered from the next state so they are glitch-free
  // and all zero in the cycle after reset.
  always_comb begin
    w_cyc_nxt  = 1'b0;
    w_we_nxt   = 1'b0;
    w_sel_nxt  = '0;
    w_data_nxt = '0;
    case (w_state_nxt)
      S_INIT_IER: begin
        w_cyc_nxt  = 1'b1;
        w_we_nxt   = 1'b1;
        w_sel_nxt  = SEL_IER;
        w_data_nxt = {16'h0000, 8'h01, 8'h00};
      end
      S_WR_THR: begin
        w_cyc_nxt  = 1'b1;
        w_we_nxt   = 1'b1;
        w_sel_nxt  = SEL_THR;
        w_data_nxt = {8'h00, (w_grant ? w_gnt_byte : r_byte), 16'h0000};
      end
      S_RD_ISR: begin
        w_cyc_nxt  = 1'b1;
        w_sel_nxt  = SEL_ISR;
      end
      default: ;
    endcase
  end

  // A grant during the reset cycle would be discarded, so it is not signalled.
  always_comb begin
    req_ready_o = '0;
    for (int j = 0; j < NUM_REQ; j++)
      req_ready_o[j] = w_grant && !rst_i && (w_gnt_idx == PTR_W'(j));
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    if (rst_i) begin
      r_state   <= S_INIT_IER;
      r_ret     <= S_IDLE;
      r_ptr     <= '0;
      r_byte    <= '0;
      r_cnt     <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ret     <= w_ret_nxt;
      if (w_grant) begin
        r_byte <= w_gnt_byte;
        r_ptr  <= w_ptr_nxt;
      end
      r_cnt     <= (r_state == S_WAIT_TX) ? r_cnt + 16'd1 : 16'd0;
      r_cyc     <= w_cyc_nxt;
      r_we      <= w_we_nxt;
      r_sel     <= w_sel_nxt;
      r_data    <= w_data_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_timeout <= w_timeout;
    end
  end

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_addr_o = 3'b000;
  assign wb_sel_o  = r_sel;
  assign wb_data_o = r_data;
  assign busy_o    = r_busy;
  assign timeout_o = r_timeout;

endmodule
